// File: rtl/uart_tx_stream_if.sv
// ---------------------------------------------------------------------------
// uart_tx_stream_if
//   Read-side handshake between the byte ring buffer and the UART transmitter.
//   master : the ring buffer (drives fifo_data / fifo_valid, receives fifo_pop)
//   slave  : the transmitter (samples fifo_data / fifo_valid, drives fifo_pop)
//   fifo_data   DATA_WIDTH  buffer out_data, registered by the buffer on the pop edge
//   fifo_valid  1           buffer non-empty
//   fifo_pop    1           buffer out_ready, one cycle per byte consumed
// ---------------------------------------------------------------------------
interface uart_tx_stream_if #(
  parameter int DATA_WIDTH = 8
);
  logic [DATA_WIDTH-1:0] fifo_data;
  logic                  fifo_valid;
  logic                  fifo_pop;

  modport master (output fifo_data, output fifo_valid, input fifo_pop);
  modport slave  (input fifo_data, input fifo_valid, output fifo_pop);
endinterface

// File: rtl/uart_tx_stream.sv
// ---------------------------------------------------------------------------
// uart_tx_stream
//   UART transmitter draining a byte ring buffer. Each byte is popped, captured
//   one cycle later (the buffer registers its data on the pop edge) and sent as
//   start bit, DATA_WIDTH data bits LSB first, optional parity, 1-2 stop bits.
// Ports
//   clk      in   system clock, rising edge
//   rst_n    in   asynchronous active-low reset
//   fifo     if   slave side of the buffer handshake (data, valid, pop)
//   tx       out  serial line, idle high
//   busy     out  high in every state except IDLE
//   tx_done  out  one-cycle pulse on the last clock of the final stop bit
// ---------------------------------------------------------------------------
module uart_tx_stream #(
  parameter int DATA_WIDTH   = 8,
  parameter int CLKS_PER_BIT = 434,
  parameter int PARITY_EN    = 0,
  parameter int PARITY_ODD   = 0,
  parameter int STOP_BITS    = 1
) (
  input  logic            clk,
  input  logic            rst_n,
  uart_tx_stream_if.slave fifo,
  output logic            tx,
  output logic            busy,
  output logic            tx_done
);

  localparam int BAUD_W = $clog2(CLKS_PER_BIT);
  localparam int BIT_W  = $clog2(DATA_WIDTH + 1);

  localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(CLKS_PER_BIT - 1);
  localparam logic [BAUD_W-1:0] BAUD_PRE  = BAUD_W'(CLKS_PER_BIT - 2);
  localparam logic [BIT_W-1:0]  DATA_LAST = BIT_W'(DATA_WIDTH - 1);
  localparam logic [BIT_W-1:0]  STOP_LAST = BIT_W'(STOP_BITS - 1);

  typedef enum logic [2:0] {
    IDLE, FETCH, LOAD, START, DATA, PARITY, STOP
  } state_e;

  state_e                state_q, state_d;
  logic [BAUD_W-1:0]     baud_q, baud_d;
  logic [BIT_W-1:0]      bit_q, bit_d;
  logic [DATA_WIDTH-1:0] shift_q, shift_d;
  logic                  parity_q, parity_d;
  logic                  tx_d, busy_d, done_d;
  logic                  baud_wrap;

  // Counter wrap marks the end of the current bit period.
  assign baud_wrap     = (baud_q == BAUD_LAST);
  // The only unregistered output: the pop must coincide with the FETCH cycle.
  assign fifo.fifo_pop = (state_q == FETCH);

  always_comb begin
    // NOTE: every signal gets a default here so no path leaves one unassigned,
    // which would otherwise infer a latch.
    state_d  = state_q;
    baud_d   = '0;
    bit_d    = bit_q;
    shift_d  = shift_q;
    parity_d = parity_q;
    tx_d     = tx;
    done_d   = 1'b0;

    unique case (state_q)
      IDLE: begin
        tx_d  = 1'b1;
        bit_d = '0;
        if (fifo.fifo_valid) state_d = FETCH;
      end

      // Sole consumer of the buffer, so valid is not re-checked after IDLE.
      FETCH: state_d = LOAD;

      LOAD: begin
        shift_d  = fifo.fifo_data;
        parity_d = (^fifo.fifo_data) ^ 1'(PARITY_ODD);
        tx_d     = 1'b0;
        bit_d    = '0;
        state_d  = START;
      end

      START: begin
        if (baud_wrap) begin
          tx_d    = shift_q[0];
          shift_d = shift_q >> 1;
          state_d = DATA;
        end else begin
          baud_d = baud_q + BAUD_W'(1);
        end
      end

      DATA: begin
        if (baud_wrap) begin
          if (bit_q == DATA_LAST) begin
            bit_d = '0;
            if (PARITY_EN != 0) begin
              tx_d    = parity_q;
              state_d = PARITY;
            end else begin
              tx_d    = 1'b1;
              state_d = STOP;
            end
          end else begin
            bit_d   = bit_q + BIT_W'(1);
            tx_d    = shift_q[0];
            shift_d = shift_q >> 1;
          end
        end else begin
          baud_d = baud_q + BAUD_W'(1);
        end
      end

      PARITY: begin
        if (baud_wrap) begin
          tx_d    = 1'b1;
          bit_d   = '0;
          state_d = STOP;
        end else begin
          baud_d = baud_q + BAUD_W'(1);
        end
      end

      STOP: begin
        tx_d = 1'b1;
        // tx_done is registered, so raise it one cycle ahead of the final stop clock.
        if (bit_q == STOP_LAST && baud_q == BAUD_PRE) done_d = 1'b1;
        if (baud_wrap) begin
          if (bit_q == STOP_LAST) begin
            bit_d   = '0;
            state_d = IDLE;
          end else begin
            bit_d = bit_q + BIT_W'(1);
          end
        end else begin
          baud_d = baud_q + BAUD_W'(1);
        end
      end

      default: state_d = IDLE;
    endcase

    busy_d = (state_d != IDLE);
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      baud_q   <= '0;
      bit_q    <= '0;
      shift_q  <= '0;
      parity_q <= 1'b0;
      tx       <= 1'b1;
      busy     <= 1'b0;
      tx_done  <= 1'b0;
    end else begin
      state_q  <= state_d;
      baud_q   <= baud_d;
      bit_q    <= bit_d;
      shift_q  <= shift_d;
      parity_q <= parity_d;
      tx       <= tx_d;
      busy     <= busy_d;
      tx_done  <= done_d;
    end
  end

endmodule

// File: tb/tb_uart_tx_stream.sv
// ---------------------------------------------------------------------------
// tb_uart_tx_stream
//   Four transmitter instances with different frame formats, each fed by its
//   own behavioural ring buffer. A cycle-level UART receiver decodes tx and
//   compares against bytes and parity computed from the frame rules.
//   dut 0 : 4 clk/bit, no parity, 1 stop
//   dut 1 : 4 clk/bit, even parity, 1 stop
//   dut 2 : 4 clk/bit, odd parity, 1 stop
//   dut 3 : 5 clk/bit, even parity, 2 stop
// ---------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_uart_tx_stream;

  localparam int NDUT = 4;
  localparam int CFG_C    [NDUT] = '{4, 4, 4, 5};
  localparam int CFG_PAR  [NDUT] = '{0, 1, 1, 1};
  localparam int CFG_ODD  [NDUT] = '{0, 0, 1, 0};
  localparam int CFG_STOP [NDUT] = '{1, 1, 1, 2};

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;
  int n_fail   = 0;

  // DUT outputs gathered per instance
  logic tx_w   [NDUT];
  logic busy_w [NDUT];
  logic done_w [NDUT];
  logic pop_w  [NDUT];

  // Behavioural ring buffers: out_data registered on the pop edge
  logic [7:0]  mem      [NDUT][256];
  int unsigned wr_ptr   [NDUT] = '{default: 0};
  int unsigned rd_ptr   [NDUT] = '{default: 0};
  logic [7:0]  out_data [NDUT] = '{default: 8'h00};
  logic        out_valid[NDUT];

  always_comb begin
    for (int k = 0; k < NDUT; k++) out_valid[k] = (wr_ptr[k] != rd_ptr[k]);
  end

  always @(posedge clk) begin
    for (int k = 0; k < NDUT; k++) begin
      if (pop_w[k] === 1'b1 && out_valid[k]) begin
        out_data[k] <= mem[k][rd_ptr[k] % 256];
        rd_ptr[k]   <= rd_ptr[k] + 1;
      end
    end
  end

  uart_tx_stream_if #(.DATA_WIDTH(8)) bus0 ();
  uart_tx_stream_if #(.DATA_WIDTH(8)) bus1 ();
  uart_tx_stream_if #(.DATA_WIDTH(8)) bus2 ();
  uart_tx_stream_if #(.DATA_WIDTH(8)) bus3 ();

  assign bus0.fifo_valid = out_valid[0];
  assign bus0.fifo_data  = out_data[0];
  assign pop_w[0]        = bus0.fifo_pop;
  assign bus1.fifo_valid = out_valid[1];
  assign bus1.fifo_data  = out_data[1];
  assign pop_w[1]        = bus1.fifo_pop;
  assign bus2.fifo_valid = out_valid[2];
  assign bus2.fifo_data  = out_data[2];
  assign pop_w[2]        = bus2.fifo_pop;
  assign bus3.fifo_valid = out_valid[3];
  assign bus3.fifo_data  = out_data[3];
  assign pop_w[3]        = bus3.fifo_pop;

  uart_tx_stream #(.DATA_WIDTH(8), .CLKS_PER_BIT(CFG_C[0]), .PARITY_EN(CFG_PAR[0]),
                   .PARITY_ODD(CFG_ODD[0]), .STOP_BITS(CFG_STOP[0])) dut0 (
    .clk(clk), .rst_n(rst_n), .fifo(bus0),
    .tx(tx_w[0]), .busy(busy_w[0]), .tx_done(done_w[0]));

  uart_tx_stream #(.DATA_WIDTH(8), .CLKS_PER_BIT(CFG_C[1]), .PARITY_EN(CFG_PAR[1]),
                   .PARITY_ODD(CFG_ODD[1]), .STOP_BITS(CFG_STOP[1])) dut1 (
    .clk(clk), .rst_n(rst_n), .fifo(bus1),
    .tx(tx_w[1]), .busy(busy_w[1]), .tx_done(done_w[1]));

  uart_tx_stream #(.DATA_WIDTH(8), .CLKS_PER_BIT(CFG_C[2]), .PARITY_EN(CFG_PAR[2]),
                   .PARITY_ODD(CFG_ODD[2]), .STOP_BITS(CFG_STOP[2])) dut2 (
    .clk(clk), .rst_n(rst_n), .fifo(bus2),
    .tx(tx_w[2]), .busy(busy_w[2]), .tx_done(done_w[2]));

  uart_tx_stream #(.DATA_WIDTH(8), .CLKS_PER_BIT(CFG_C[3]), .PARITY_EN(CFG_PAR[3]),
                   .PARITY_ODD(CFG_ODD[3]), .STOP_BITS(CFG_STOP[3])) dut3 (
    .clk(clk), .rst_n(rst_n), .fifo(bus3),
    .tx(tx_w[3]), .busy(busy_w[3]), .tx_done(done_w[3]));

  // Pop monitor: every pop must be a lone cycle, with the line idle and the buffer non-empty.
  int   pop_cnt  [NDUT] = '{default: 0};
  int   pop_bad  [NDUT] = '{default: 0};
  logic prev_pop [NDUT] = '{default: 1'b0};

  always @(negedge clk) begin
    for (int k = 0; k < NDUT; k++) begin
      if (rst_n) begin
        if (pop_w[k] === 1'b1) begin
          pop_cnt[k] <= pop_cnt[k] + 1;
          if (prev_pop[k] || tx_w[k] !== 1'b1 || !out_valid[k]) pop_bad[k] <= pop_bad[k] + 1;
        end
        prev_pop[k] <= (pop_w[k] === 1'b1);
      end else begin
        prev_pop[k] <= 1'b0;
      end
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic push(input int k, input logic [7:0] b);
    mem[k][wr_ptr[k] % 256] = b;
    wr_ptr[k] = wr_ptr[k] + 1;
  endtask

  // Parity bit that makes the count of ones even (or odd when odd != 0).
  function automatic logic ref_parity(input logic [7:0] b, input int odd);
    int ones;
    ones = $countones(b);
    return ((ones % 2) == 1) ^ (odd != 0);
  endfunction

  // Cycle-level receiver. Waits (bounded) for the start bit, then samples every
  // clock of the frame: each bit must hold its first-cycle value for CLKS_PER_BIT
  // cycles, tx_done may be high only on the frame's final clock, busy throughout.
  task automatic rx_frame(input int k, input int budget,
                          output logic [7:0] data, output logic par,
                          output int glitches, output logic stop_ok,
                          output logic done_ok, output logic busy_ok,
                          output int wait_n, output logic timed_out);
    int   c, nb, stop_first;
    logic v, first;
    c          = CFG_C[k];
    nb         = 1 + 8 + CFG_PAR[k] + CFG_STOP[k];
    stop_first = nb - CFG_STOP[k];
    data = '0; par = 1'b0; glitches = 0;
    stop_ok = 1'b1; done_ok = 1'b1; busy_ok = 1'b1; first = 1'b0;
    wait_n = 0;
    while (tx_w[k] !== 1'b0 && wait_n < budget) begin
      @(negedge clk);
      wait_n++;
    end
    timed_out = (tx_w[k] !== 1'b0);
    if (!timed_out) begin
      for (int j = 0; j < nb; j++) begin
        for (int cyc = 0; cyc < c; cyc++) begin
          if (j != 0 || cyc != 0) @(negedge clk);
          v = tx_w[k];
          if (cyc == 0) begin
            first = v;
            if (j >= 1 && j <= 8) data[j-1] = v;
            else if (j == 9 && CFG_PAR[k] != 0) par = v;
            else if (j >= stop_first && v !== 1'b1) stop_ok = 1'b0;
          end else if (v !== first) begin
            glitches++;
          end
          if ((done_w[k] === 1'b1) != (j == nb - 1 && cyc == c - 1)) done_ok = 1'b0;
          if (busy_w[k] !== 1'b1) busy_ok = 1'b0;
        end
      end
    end
  endtask

  task automatic check_frame(input int k, input string tag, input logic [7:0] exp_b,
                             input int budget, output int wait_n);
    logic [7:0] d;
    logic       p, stop_ok, done_ok, busy_ok, to;
    int         gl;
    rx_frame(k, budget, d, p, gl, stop_ok, done_ok, busy_ok, wait_n, to);
    check({tag, " start timeout"}, 32'(to), 32'd0);
    if (!to) begin
      check({tag, " data"}, 32'(d), 32'(exp_b));
      if (CFG_PAR[k] != 0) check({tag, " parity"}, 32'(p), 32'(ref_parity(exp_b, CFG_ODD[k])));
      check({tag, " bit timing"}, 32'(gl), 32'd0);
      check({tag, " stop bits"}, 32'(stop_ok), 32'd1);
      check({tag, " tx_done position"}, 32'(done_ok), 32'd1);
      check({tag, " busy in frame"}, 32'(busy_ok), 32'd1);
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int         w, w1, w2, w3, p_before, n;
    int         bad_pop, bad_tx, bad_busy, bad_done;
    logic [7:0] rnd [12];

    // Reset state
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    for (int k = 0; k < NDUT; k += 3) begin
      check($sformatf("reset tx dut%0d", k),   32'(tx_w[k]),   32'd1);
      check($sformatf("reset busy dut%0d", k), 32'(busy_w[k]), 32'd0);
      check($sformatf("reset pop dut%0d", k),  32'(pop_w[k]),  32'd0);
      check($sformatf("reset done dut%0d", k), 32'(done_w[k]), 32'd0);
    end
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    // T1: 0xA5, pop for one cycle, start bit three cycles after valid is seen
    push(0, 8'hA5);
    @(negedge clk);
    check("T1 pop at N+1", 32'(pop_w[0]), 32'd1);
    @(negedge clk);
    check("T1 pop single cycle", 32'(pop_w[0]), 32'd0);
    check_frame(0, "T1", 8'hA5, 20, w);
    check("T1 tx falls at N+3", 32'(w), 32'd1);
    repeat (2) @(negedge clk);
    #1;
    check("T1 pop count", 32'(pop_cnt[0]), 32'd1);
    check("T1 idle after frame", 32'(busy_w[0]), 32'd0);

    // T2: same byte with even and odd parity, 44-cycle frames
    push(1, 8'hA5);
    push(2, 8'hA5);
    fork
      check_frame(1, "T2 even", 8'hA5, 20, w1);
      check_frame(2, "T2 odd",  8'hA5, 20, w2);
    join
    check("T2 even latency", 32'(w1), 32'd3);
    check("T2 odd latency",  32'(w2), 32'd3);

    // T3: three bytes back-to-back, two stop bits
    p_before = pop_cnt[3];
    push(3, 8'h00);
    push(3, 8'hFF);
    push(3, 8'h3C);
    check_frame(3, "T3 f0", 8'h00, 20, w1);
    check_frame(3, "T3 f1", 8'hFF, 20, w2);
    check_frame(3, "T3 f2", 8'h3C, 20, w3);
    check("T3 first latency", 32'(w1), 32'd3);
    check("T3 gap 1 high cycles", 32'(w2 - 1), 32'd3);
    check("T3 gap 2 high cycles", 32'(w3 - 1), 32'd3);
    repeat (3) @(negedge clk);
    #1;
    check("T3 pop count", 32'(pop_cnt[3] - p_before), 32'd3);
    check("T3 buffer drained", 32'(out_valid[3]), 32'd0);
    check("T3 back to idle", 32'(busy_w[3]), 32'd0);

    // T4: empty buffer for 1000 cycles
    bad_pop = 0; bad_tx = 0; bad_busy = 0; bad_done = 0;
    repeat (1000) begin
      @(negedge clk);
      if (pop_w[0]  !== 1'b0) bad_pop++;
      if (tx_w[0]   !== 1'b1) bad_tx++;
      if (busy_w[0] !== 1'b0) bad_busy++;
      if (done_w[0] !== 1'b0) bad_done++;
    end
    check("T4 pop cycles",  32'(bad_pop),  32'd0);
    check("T4 tx low",      32'(bad_tx),   32'd0);
    check("T4 busy cycles", 32'(bad_busy), 32'd0);
    check("T4 done cycles", 32'(bad_done), 32'd0);

    // T5: asynchronous reset during data bit 3 of 0x55
    p_before = pop_cnt[0];
    push(0, 8'h55);
    n = 0;
    while (tx_w[0] !== 1'b0 && n < 20) begin
      @(negedge clk);
      n++;
    end
    check("T5 start seen", 32'(tx_w[0]), 32'd0);
    push(0, 8'hC3);
    repeat (17) @(negedge clk);
    check("T5 in data bit 3", 32'(tx_w[0]), 32'd0);
    #2 rst_n = 1'b0;
    #1;
    check("T5 async tx",   32'(tx_w[0]),   32'd1);
    check("T5 async busy", 32'(busy_w[0]), 32'd0);
    check("T5 async pop",  32'(pop_w[0]),  32'd0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    check_frame(0, "T5 after reset", 8'hC3, 20, w);
    repeat (2) @(negedge clk);
    #1;
    check("T5 pop count", 32'(pop_cnt[0] - p_before), 32'd2);

    // T6: random bytes with random push gaps against the receiver model
    p_before = pop_cnt[3];
    for (int i = 0; i < 12; i++) rnd[i] = 8'($urandom_range(0, 255));
    fork
      begin
        for (int i = 0; i < 12; i++) begin
          repeat ($urandom_range(0, 70)) @(negedge clk);
          push(3, rnd[i]);
        end
      end
      begin
        for (int i = 0; i < 12; i++) begin
          check_frame(3, $sformatf("T6 byte %0d", i), rnd[i], 3000, w);
        end
      end
    join
    repeat (3) @(negedge clk);
    #1;
    check("T6 pop count", 32'(pop_cnt[3] - p_before), 32'd12);

    // All pushed bytes consumed, every pop a clean single cycle
    for (int k = 0; k < NDUT; k++) begin
      check($sformatf("pops equal pushes dut%0d", k), 32'(pop_cnt[k]), 32'(wr_ptr[k]));
      check($sformatf("pop protocol dut%0d", k), 32'(pop_bad[k]), 32'd0);
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
